// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FIFO and FIFO-reader parameters
package fifo_pkg;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CNT_WIDTH  = 16;
  localparam int FIFO_DEPTH     = 16;
  localparam int SKID_DEPTH     = 2;
endpackage

// File: rtl/fifo_reader_skid.sv
// fifo_reader_skid: 2-entry in-order output buffer
// ports: rd_clk/rst_n clock and async active-low reset; push/push_data append at tail;
//        pop removes head; occ entry count 0..2; head oldest word (0 after reset)
module fifo_reader_skid import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occ,
  output logic [DATA_WIDTH-1:0] head
);
  logic [DATA_WIDTH-1:0] tail, head_nxt, tail_nxt;
  logic [1:0] occ_rem, occ_nxt;
  // occ_rem is what survives the pop; a push lands right behind it
  always_comb begin
    occ_rem  = occ - {1'b0, pop};
    head_nxt = (push && occ_rem == 2'd0) ? push_data : (pop ? tail : head);
    tail_nxt = (push && occ_rem == 2'd1) ? push_data : tail;
    occ_nxt  = occ_rem + {1'b0, push};
  end
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      occ  <= occ_nxt;
      head <= head_nxt;
      tail <= tail_nxt;
    end
  end
endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: pops a FIFO into a valid/ready stream through a 2-entry buffer
// ports: rd_clk/rst_n clock and async active-low reset; fifo_empty/fifo_rd_en/fifo_rd_data
//        FIFO read side (data one cycle after pop); m_valid/m_ready/m_data output stream;
//        rd_count words delivered since reset (wraps)
module fifo_reader import fifo_pkg::*; #(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  rd_clk,
  input  logic                  rst_n,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic [CNT_WIDTH-1:0]  rd_count
);
  logic [1:0] occ;
  logic [2:0] demand;
  logic inflight, armed, transfer;
  // armed holds pops off until the first edge after reset release
  always_comb begin
    m_valid    = occ != 2'd0;
    transfer   = m_valid && m_ready;
    demand     = {1'b0, occ} + {2'b0, inflight} - {2'b0, transfer};
    fifo_rd_en = armed && !fifo_empty && demand <= 3'd1;
  end
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      armed    <= 1'b0;
      inflight <= 1'b0;
      rd_count <= '0;
    end else begin
      armed    <= 1'b1;
      inflight <= fifo_rd_en;
      rd_count <= rd_count + CNT_WIDTH'(transfer);
    end
  end
  fifo_reader_skid #(.DATA_WIDTH(DATA_WIDTH)) u_skid (
    .rd_clk    (rd_clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .pop       (transfer),
    .occ       (occ),
    .head      (m_data)
  );
endmodule

// File: tb/tb_fifo_reader.sv
// tb_fifo_reader: directed self-checking bench for fifo_reader
module tb_fifo_reader;
  logic rd_clk = 1'b0;
  logic rst_n;
  logic fifo_empty = 1'b1;
  logic fifo_rd_en;
  logic [7:0] fifo_rd_data = 8'h00;
  logic m_valid, m_ready;
  logic [7:0] m_data;
  logic [15:0] rd_count;
  logic w_empty, w_rd_en, w_valid, w_ready;
  logic [7:0] w_rd_data, w_data;
  logic [3:0] w_count;
  logic [7:0] fq[$];
  int viol = 0;
  int compared = 0;
  int mismatched = 0;

  always #5 rd_clk = ~rd_clk;

  fifo_reader u_dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_rd_data(fifo_rd_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .rd_count(rd_count)
  );

  fifo_reader #(.DATA_WIDTH(8), .CNT_WIDTH(4)) u_w (
    .rd_clk(rd_clk), .rst_n(rst_n), .fifo_empty(w_empty), .fifo_rd_en(w_rd_en),
    .fifo_rd_data(w_rd_data), .m_valid(w_valid), .m_ready(w_ready), .m_data(w_data),
    .rd_count(w_count)
  );

  // FIFO model: pop on accepted read, data valid one cycle later
  always @(posedge rd_clk) begin
    if (fifo_rd_en && fifo_empty) viol <= viol + 1;
    if (fifo_rd_en && !fifo_empty) fifo_rd_data <= fq.pop_front();
    fifo_empty <= (fq.size() == 0);
  end

  task automatic tick;
    @(negedge rd_clk);
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    m_ready = 1'b0;
    w_ready = 1'b0;
    fq.delete();
    repeat (2) tick();
  endtask

  task automatic test_reset;
    do_reset();
    fq.push_back(8'h55);
    repeat (2) tick();
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    compared++; if (fifo_rd_en !== 1'b0) begin mismatched++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
    compared++; if (rd_count !== 16'd0) begin mismatched++; $display("FAIL reset_rd_count got=%0d exp=0", rd_count); end
    compared++; if (m_data !== 8'h00) begin mismatched++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
  endtask

  task automatic test_stream;
    int c = 0;
    do_reset();
    for (int i = 1; i <= 5; i++) fq.push_back(8'(i));
    tick();
    m_ready = 1'b1;
    rst_n = 1'b1;
    while (!fifo_rd_en && c < 10) begin tick(); c++; end
    compared++; if (fifo_rd_en !== 1'b1) begin mismatched++; $display("FAIL stream_first_pop got=%b exp=1", fifo_rd_en); end
    repeat (2) tick();
    for (int k = 0; k < 5; k++) begin
      compared++;
      if (m_valid !== 1'b1 || m_data !== 8'(k + 1)) begin
        mismatched++; $display("FAIL stream_word%0d got=%b/%h exp=1/%h", k, m_valid, m_data, 8'(k + 1));
      end
      tick();
    end
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL stream_drained got=%b exp=0", m_valid); end
    compared++; if (rd_count !== 16'd5) begin mismatched++; $display("FAIL stream_count got=%0d exp=5", rd_count); end
    compared++; if (fifo_rd_en !== 1'b0) begin mismatched++; $display("FAIL stream_rd_en_idle got=%b exp=0", fifo_rd_en); end
  endtask

  task automatic test_backpressure;
    int pops = 0;
    int unstable = 0;
    int got = 0;
    int c = 0;
    do_reset();
    for (int i = 0; i < 4; i++) fq.push_back(8'hA0 + 8'(i));
    tick();
    rst_n = 1'b1;
    repeat (10) begin
      tick();
      if (fifo_rd_en && !fifo_empty) pops++;
      if (m_valid && m_data !== 8'hA0) unstable++;
    end
    compared++; if (pops !== 2) begin mismatched++; $display("FAIL bp_pops got=%0d exp=2", pops); end
    compared++; if (u_dut.occ !== 2'd2) begin mismatched++; $display("FAIL bp_occ got=%0d exp=2", u_dut.occ); end
    compared++; if (unstable !== 0 || m_data !== 8'hA0) begin mismatched++; $display("FAIL bp_hold got=%h unstable=%0d exp=a0", m_data, unstable); end
    m_ready = 1'b1;
    while (got < 4 && c < 20) begin
      if (m_valid && m_ready) begin
        compared++;
        if (m_data !== 8'hA0 + 8'(got)) begin mismatched++; $display("FAIL bp_word%0d got=%h exp=%h", got, m_data, 8'hA0 + 8'(got)); end
        got++;
      end
      tick(); c++;
    end
    repeat (3) tick();
    compared++; if (got !== 4 || rd_count !== 16'd4) begin mismatched++; $display("FAIL bp_count got=%0d/%0d exp=4/4", got, rd_count); end
    compared++; if (m_valid !== 1'b0) begin mismatched++; $display("FAIL bp_no_dup got=%b exp=0", m_valid); end
  endtask

  task automatic test_empty;
    do_reset();
    m_ready = 1'b1;
    rst_n = 1'b1;
    repeat (8) begin
      tick();
      compared++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
        mismatched++; $display("FAIL empty_idle got=%b/%b exp=0/0", fifo_rd_en, m_valid);
      end
    end
    compared++; if (rd_count !== 16'd0) begin mismatched++; $display("FAIL empty_count got=%0d exp=0", rd_count); end
  endtask

  task automatic test_random;
    int got = 0;
    int c = 0;
    int err = 0;
    int v0;
    do_reset();
    v0 = viol;
    for (int i = 0; i < 1000; i++) fq.push_back(8'(i));
    tick();
    rst_n = 1'b1;
    while (got < 1000 && c < 10000) begin
      m_ready = 1'($urandom_range(0, 1));
      if (m_valid && m_ready) begin
        if (m_data !== 8'(got)) begin
          if (err == 0) $display("FAIL random_word%0d got=%h exp=%h", got, m_data, 8'(got));
          err++;
        end
        got++;
      end
      tick(); c++;
    end
    m_ready = 1'b0;
    tick();
    compared++; if (err !== 0) begin mismatched++; $display("FAIL random_order got=%0d errors exp=0", err); end
    compared++; if (got !== 1000 || rd_count !== 16'd1000) begin mismatched++; $display("FAIL random_count got=%0d/%0d exp=1000", got, rd_count); end
    compared++; if (viol !== v0) begin mismatched++; $display("FAIL random_pop_when_empty got=%0d exp=%0d", viol, v0); end
  endtask

  task automatic test_wrap;
    int n = 0;
    int c = 0;
    do_reset();
    rst_n = 1'b1;
    w_ready = 1'b1;
    while (n < 17 && c < 100) begin
      if (w_valid && w_ready) n++;
      tick(); c++;
    end
    w_ready = 1'b0;
    tick();
    compared++; if (n !== 17 || w_count !== 4'd1) begin mismatched++; $display("FAIL wrap_count got=%0d after %0d exp=1 after 17", w_count, n); end
  endtask

  task automatic test_reset_mid;
    logic [7:0] snap[$];
    int got = 0;
    int c = 0;
    do_reset();
    for (int i = 0; i < 16; i++) fq.push_back(8'h10 + 8'(i));
    tick();
    m_ready = 1'b1;
    rst_n = 1'b1;
    repeat (6) tick();
    compared++; if (u_dut.inflight !== 1'b1 || m_valid !== 1'b1) begin mismatched++; $display("FAIL mid_busy got=%b/%b exp=1/1", u_dut.inflight, m_valid); end
    rst_n = 1'b0;
    #1;
    compared++; if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin mismatched++; $display("FAIL mid_async_valid got=%b/%b exp=0/0", m_valid, fifo_rd_en); end
    compared++; if (rd_count !== 16'd0 || m_data !== 8'h00) begin mismatched++; $display("FAIL mid_async_count got=%0d/%h exp=0/00", rd_count, m_data); end
    snap = fq;
    repeat (2) tick();
    rst_n = 1'b1;
    while (got < 3 && c < 20) begin
      if (m_valid && m_ready) begin
        compared++;
        if (m_data !== snap[got]) begin mismatched++; $display("FAIL mid_word%0d got=%h exp=%h", got, m_data, snap[got]); end
        got++;
      end
      tick(); c++;
    end
    compared++; if (got !== 3) begin mismatched++; $display("FAIL mid_delivered got=%0d exp=3", got); end
  endtask

  initial begin
    rst_n = 1'b0;
    m_ready = 1'b0;
    w_ready = 1'b0;
    w_empty = 1'b0;
    w_rd_data = 8'h3C;
    test_reset();
    test_stream();
    test_backpressure();
    test_empty();
    test_random();
    test_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
